alu_mul_sequencer: RTL and testbench

ALU_MUL_SEQUENCER -- requirements
Module: alu_mul_sequencer

---
 rtl/alu_mul_sequencer_pkg.sv | 39 +++
 rtl/alu_mul_sequencer.sv | 132 +++++++++++++
 tb/tb_alu_mul_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/alu_mul_sequencer_pkg.sv
// ============================================================================
// Module : alu_mul_sequencer_pkg
// Brief  : Shared ALU function selects, flag indices and sequencer states.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_mul_sequencer_pkg;

  localparam logic [4:0] PASS_A32 = 5'b10000;
  localparam logic [4:0] ADD32    = 5'b10100;
  localparam logic [4:0] LSL32    = 5'b11011;

  localparam int ZERO     = 3;
  localparam int CARRY    = 2;
  localparam int NEGATIVE = 1;
  localparam int OVERFLOW = 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADD   = 3'd1,
    S_SHIFT = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Pick the next step from the multiplier bits still to be consumed.
  function automatic state_e step_state(input logic [15:0] q);
    if (q == 16'd0)
      return S_FINAL;
    else if (q[0])
      return S_ADD;
    else
      return S_SHIFT;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_mul_sequencer.sv
// ============================================================================
// Module : alu_mul_sequencer
// Brief  : Shift-and-add 16x16 multiplier sequencing an external 32-bit ALU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] OpA,
  input  logic [15:0] OpB,
  output logic [31:0] AluA,
  output logic [31:0] AluB,
  output logic [4:0]  AluFunSel,
  output logic        AluWF,
  input  logic [31:0] AluOut,
  input  logic [3:0]  AluFlags,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Product,
  output logic        ProductZero
);

  state_e      state_q, state_d;
  logic [31:0] p_q, p_d;
  logic [31:0] m_q, m_d;
  logic [15:0] q_q, q_d;
  logic [31:0] product_q, product_d;
  logic        zero_q, zero_d;
  logic        done_q, done_d;

  // Carry, sign and overflow never matter: a 16x16 product always fits.
  logic unused_flags;
  assign unused_flags = ^AluFlags[2:0];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      p_q       <= 32'd0;
      m_q       <= 32'd0;
      q_q       <= 16'd0;
      product_q <= 32'd0;
      zero_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      m_q       <= m_d;
      q_q       <= q_d;
      product_q <= product_d;
      zero_q    <= zero_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Start) state_d = step_state(OpB);
      S_ADD:   state_d = S_SHIFT;
      S_SHIFT: state_d = step_state(q_q >> 1);
      S_FINAL: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    p_d       = p_q;
    m_d       = m_q;
    q_d       = q_q;
    product_d = product_q;
    zero_d    = zero_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          p_d = 32'd0;
          m_d = {16'd0, OpA};
          q_d = OpB;
        end
      end
      S_ADD:   p_d = AluOut;
      S_SHIFT: begin
        m_d = AluOut;
        q_d = q_q >> 1;
      end
      // The ALU registered Z for P on the edge that closed FINAL.
      S_DONE: begin
        product_d = p_q;
        zero_d    = AluFlags[ZERO];
        done_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    AluA      = 32'd0;
    AluB      = 32'd0;
    AluFunSel = PASS_A32;
    case (state_q)
      S_ADD: begin
        AluA      = p_q;
        AluB      = m_q;
        AluFunSel = ADD32;
      end
      S_SHIFT: begin
        AluA      = m_q;
        AluFunSel = LSL32;
      end
      S_FINAL: begin
        AluA      = p_q;
        AluFunSel = PASS_A32;
      end
      default: ;
    endcase
  end

  assign AluWF       = 1'b0;
  assign Busy        = (state_q != S_IDLE);
  assign Done        = done_q;
  assign Product     = product_q;
  assign ProductZero = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_mul_sequencer.sv
// ============================================================================
// Module : tb_alu_mul_sequencer
// Brief  : Scoreboard bench for alu_mul_sequencer with a behavioural ALU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_mul_sequencer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [15:0] OpA   = 16'd0;
  logic [15:0] OpB   = 16'd0;
  logic [31:0] AluA, AluB, AluOut;
  logic [4:0]  AluFunSel;
  logic        AluWF;
  logic [3:0]  AluFlags = 4'd0;
  logic        Busy, Done, ProductZero;
  logic [31:0] Product;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] p;
    logic        z;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  alu_mul_sequencer dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .OpA(OpA), .OpB(OpB),
    .AluA(AluA), .AluB(AluB), .AluFunSel(AluFunSel), .AluWF(AluWF),
    .AluOut(AluOut), .AluFlags(AluFlags), .Busy(Busy), .Done(Done),
    .Product(Product), .ProductZero(ProductZero)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  // Behavioural stand-in for the team ALU: combinational result, registered flags.
  logic [32:0] alu_sum;
  always_comb begin
    alu_sum = {1'b0, AluA} + {1'b0, AluB} + {32'd0, AluWF};
    case (AluFunSel)
      5'b10100: AluOut = alu_sum[31:0];
      5'b11011: AluOut = AluA << 1;
      5'b10000: AluOut = AluA;
      default:  AluOut = 32'd0;
    endcase
  end
  always @(posedge Clock)
    AluFlags <= {AluOut == 32'd0, alu_sum[32], AluOut[31], 1'b0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge Clock) begin
    if (Done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("product", {32'd0, Product}, {32'd0, e.p});
        check("product_zero", {63'd0, ProductZero}, {63'd0, e.z});
        check("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic push(input logic [31:0] p, input logic z, input int at);
    exp_t e;
    e.p = p; e.z = z; e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] p, input logic z, input int lat);
    @(posedge Clock); #1;
    Start = 1'b1; OpA = a; OpB = b;
    push(p, z, cyc + lat);
    @(posedge Clock); #1;
    Start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge Clock);
    check("drain", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (4) @(posedge Clock);
  endtask

  initial begin
    repeat (3) @(posedge Clock);
    #1 Reset = 1'b0;
    check("rst_busy", {63'd0, Busy}, 64'd0);
    check("rst_done", {63'd0, Done}, 64'd0);
    check("rst_product", {32'd0, Product}, 64'd0);
    check("rst_pzero", {63'd0, ProductZero}, 64'd0);
    check("rst_alua", {32'd0, AluA}, 64'd0);
    check("rst_alub", {32'd0, AluB}, 64'd0);
    check("rst_funsel", {59'd0, AluFunSel}, 64'h10);
    check("rst_wf", {63'd0, AluWF}, 64'd0);

    start_op(16'd3, 16'd5, 32'h0000000F, 1'b0, 8);
    check("busy_mid_op", {63'd0, Busy}, 64'd1);
    drain();
    start_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b0, 35);
    drain();
    start_op(16'h1234, 16'h0000, 32'd0, 1'b1, 3);
    drain();
    start_op(16'h0000, 16'h8000, 32'd0, 1'b1, 20);
    drain();

    // Second Start during a busy 2x3 must be ignored entirely.
    start_op(16'd2, 16'd3, 32'd6, 1'b0, 7);
    @(posedge Clock); #1;
    Start = 1'b1; OpA = 16'd7; OpB = 16'd7;
    @(posedge Clock); #1;
    Start = 1'b0;
    drain();

    // Abort a long multiply with reset four cycles in.
    @(posedge Clock); #1;
    Start = 1'b1; OpA = 16'hFFFF; OpB = 16'hFFFF;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    check("busy_before_reset", {63'd0, Busy}, 64'd1);
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    check("reset_busy", {63'd0, Busy}, 64'd0);
    check("reset_product", {32'd0, Product}, 64'd0);
    check("reset_done", {63'd0, Done}, 64'd0);
    repeat (40) @(posedge Clock);
    start_op(16'd2, 16'd2, 32'd4, 1'b0, 6);
    drain();

    // Start held high: each new operation is taken in its predecessor's Done cycle.
    @(posedge Clock); #1;
    Start = 1'b1; OpA = 16'd5; OpB = 16'd3;
    push(32'd15, 1'b0, cyc + 7);
    repeat (7) @(posedge Clock);
    #1;
    OpA = 16'h0100; OpB = 16'd0;
    push(32'd0, 1'b1, cyc + 3);
    repeat (3) @(posedge Clock);
    #1;
    OpA = 16'd2; OpB = 16'd6;
    push(32'd12, 1'b0, cyc + 8);
    @(posedge Clock); #1;
    Start = 1'b0;
    drain();
    repeat (10) @(posedge Clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
